// File: rtl/x2050ryarb_if.sv
// Handshake bundle between the ROS/channel requesters and the RY/LX arbiter.
// o_ch_err exists only when X2050_RYARB_CODECHK_EN is defined.
interface x2050ryarb_if;
  logic       i_ros_valid;
  logic [2:0] i_ros_ry;
  logic [2:0] i_ros_lx;
  logic       i_ch_req;
  logic [2:0] i_ch_ry;
  logic [2:0] i_ch_lx;
  logic [1:0] i_ch_len;
  logic [2:0] o_ry;
  logic [2:0] o_lx;
  logic       o_ch_gnt;
  logic       o_ch_beat;
  logic       o_ros_stall;
`ifdef X2050_RYARB_CODECHK_EN
  logic       o_ch_err;
`endif

  modport slave (
    input  i_ros_valid, i_ros_ry, i_ros_lx,
    input  i_ch_req, i_ch_ry, i_ch_lx, i_ch_len,
    output o_ry, o_lx, o_ch_gnt, o_ch_beat, o_ros_stall
`ifdef X2050_RYARB_CODECHK_EN
    , output o_ch_err
`endif
  );

  modport master (
    output i_ros_valid, i_ros_ry, i_ros_lx,
    output i_ch_req, i_ch_ry, i_ch_lx, i_ch_len,
    input  o_ry, o_lx, o_ch_gnt, o_ch_beat, o_ros_stall
`ifdef X2050_RYARB_CODECHK_EN
    , input o_ch_err
`endif
  );
endinterface

// File: rtl/x2050ryarb.sv
// Right adder input (RY/LX) arbiter: ROS microword vs. channel cycle-steal bursts.
// Optional macro X2050_RYARB_CODECHK_EN refuses channel grants carrying RY codes 6/7.
module x2050ryarb #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input logic         i_clk,
  input logic         i_reset,
  x2050ryarb_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [1:0]       beats_left, beats_left_n;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_n;
  logic             fair, fair_n;
  logic [2:0]       lat_ry, lat_ry_n;
  logic [2:0]       lat_lx, lat_lx_n;
  logic [2:0]       ry_q, ry_n;
  logic [2:0]       lx_q, lx_n;
  logic             gnt_q, gnt_n;
  logic             beat_q, beat_n;
  logic             stall_q, stall_n;
  logic             err_q, err_n;
  logic             ch_win;
  logic             ry_illegal;

  // The channel wins only when ROS is idle or has starved it long enough.
  assign ch_win     = bus.i_ch_req && !fair &&
                      (!bus.i_ros_valid || (starve_cnt == LIMIT));
  assign ry_illegal = (bus.i_ch_ry > 3'd5);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state      <= IDLE;
      beats_left <= '0;
      starve_cnt <= '0;
      fair       <= 1'b0;
      lat_ry     <= '0;
      lat_lx     <= '0;
      ry_q       <= '0;
      lx_q       <= '0;
      gnt_q      <= 1'b0;
      beat_q     <= 1'b0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      beats_left <= beats_left_n;
      starve_cnt <= starve_cnt_n;
      fair       <= fair_n;
      lat_ry     <= lat_ry_n;
      lat_lx     <= lat_lx_n;
      ry_q       <= ry_n;
      lx_q       <= lx_n;
      gnt_q      <= gnt_n;
      beat_q     <= beat_n;
      stall_q    <= stall_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    beats_left_n = beats_left;
    starve_cnt_n = starve_cnt;
    fair_n       = fair;
    lat_ry_n     = lat_ry;
    lat_lx_n     = lat_lx;
    ry_n         = '0;
    lx_n         = '0;
    gnt_n        = 1'b0;
    beat_n       = 1'b0;
    stall_n      = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        fair_n = 1'b0;
        if (ch_win) begin
          starve_cnt_n = '0;
`ifdef X2050_RYARB_CODECHK_EN
          if (ry_illegal) begin
            // Refused grant: flag the error but keep serving ROS this cycle.
            gnt_n = 1'b1;
            err_n = 1'b1;
            if (bus.i_ros_valid) begin
              ry_n = bus.i_ros_ry;
              lx_n = bus.i_ros_lx;
            end
          end else begin
            lat_ry_n = bus.i_ch_ry;
            lat_lx_n = bus.i_ch_lx;
            ry_n     = bus.i_ch_ry;
            lx_n     = bus.i_ch_lx;
            gnt_n    = 1'b1;
            beat_n   = 1'b1;
            stall_n  = bus.i_ros_valid;
            if (bus.i_ch_len != 2'd0) begin
              state_n      = XFER;
              beats_left_n = bus.i_ch_len;
            end else begin
              fair_n = 1'b1;
            end
          end
`else
          // Without code checking, illegal RY codes degrade to the zero source.
          lat_ry_n = ry_illegal ? 3'd0 : bus.i_ch_ry;
          lat_lx_n = bus.i_ch_lx;
          ry_n     = ry_illegal ? 3'd0 : bus.i_ch_ry;
          lx_n     = bus.i_ch_lx;
          gnt_n    = 1'b1;
          beat_n   = 1'b1;
          stall_n  = bus.i_ros_valid;
          if (bus.i_ch_len != 2'd0) begin
            state_n      = XFER;
            beats_left_n = bus.i_ch_len;
          end else begin
            fair_n = 1'b1;
          end
`endif
        end else if (bus.i_ros_valid) begin
          ry_n = bus.i_ros_ry;
          lx_n = bus.i_ros_lx;
          if (bus.i_ch_req && (starve_cnt < LIMIT)) begin
            starve_cnt_n = starve_cnt + CNT_W'(1);
          end
        end
      end

      XFER: begin
        // beats_left counts the beats still owed after the one already on the outputs.
        ry_n         = lat_ry;
        lx_n         = lat_lx;
        beat_n       = 1'b1;
        stall_n      = 1'b1;
        beats_left_n = beats_left - 2'd1;
        if (beats_left == 2'd1) begin
          state_n = IDLE;
          fair_n  = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.o_ry        = ry_q;
  assign bus.o_lx        = lx_q;
  assign bus.o_ch_gnt    = gnt_q;
  assign bus.o_ch_beat   = beat_q;
  assign bus.o_ros_stall = stall_q;
`ifdef X2050_RYARB_CODECHK_EN
  assign bus.o_ch_err    = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_x2050ryarb.sv
// Directed scoreboard bench for x2050ryarb: expectations are queued when stimulus is
// driven and popped after the following rising edge.
module tb_x2050ryarb;

  typedef struct {
    string      tag;
    logic [2:0] ry;
    logic [2:0] lx;
    logic       gnt;
    logic       beat;
    logic       stall;
    logic       err;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  exp_t sb[$];

  x2050ryarb_if bus ();

  x2050ryarb #(
    .STARVE_LIMIT(8),
    .CNT_W       (4)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input string field, input logic [2:0] obs,
                     input logic [2:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input logic rn, input logic rv, input logic [2:0] rry,
                                input logic [2:0] rlx, input logic cr,
                                input logic [2:0] cry, input logic [2:0] clx,
                                input logic [1:0] cl);
    @(negedge clk);
    reset_n         = rn;
    bus.i_ros_valid = rv;
    bus.i_ros_ry    = rry;
    bus.i_ros_lx    = rlx;
    bus.i_ch_req    = cr;
    bus.i_ch_ry     = cry;
    bus.i_ch_lx     = clx;
    bus.i_ch_len    = cl;
  endtask

  task automatic check_output();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb.pop_front();
      cmp(e.tag, "ry", bus.o_ry, e.ry);
      cmp(e.tag, "lx", bus.o_lx, e.lx);
      cmp(e.tag, "gnt", {2'b00, bus.o_ch_gnt}, {2'b00, e.gnt});
      cmp(e.tag, "beat", {2'b00, bus.o_ch_beat}, {2'b00, e.beat});
      cmp(e.tag, "stall", {2'b00, bus.o_ros_stall}, {2'b00, e.stall});
`ifdef X2050_RYARB_CODECHK_EN
      cmp(e.tag, "err", {2'b00, bus.o_ch_err}, {2'b00, e.err});
`endif
    end
  endtask

  // One cycle: drive inputs, queue the outputs expected after the next edge, check them.
  task automatic step(input string tag, input logic rn, input logic rv,
                      input logic [2:0] rry, input logic [2:0] rlx, input logic cr,
                      input logic [2:0] cry, input logic [2:0] clx, input logic [1:0] cl,
                      input logic [2:0] ery, input logic [2:0] elx, input logic eg,
                      input logic eb, input logic es, input logic ee);
    exp_t e;
    apply_stimulus(rn, rv, rry, rlx, cr, cry, clx, cl);
    e.tag = tag; e.ry = ery; e.lx = elx; e.gnt = eg; e.beat = eb; e.stall = es; e.err = ee;
    sb.push_back(e);
    check_output();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n         = 1'b0;
    bus.i_ros_valid = 1'b0;
    bus.i_ros_ry    = '0;
    bus.i_ros_lx    = '0;
    bus.i_ch_req    = 1'b0;
    bus.i_ch_ry     = '0;
    bus.i_ch_lx     = '0;
    bus.i_ch_len    = '0;

    // Reset held with both requesters active
    step("rst0", 0, 1, 2, 5, 1, 4, 3, 2,  0, 0, 0, 0, 0, 0);
    step("rst1", 0, 1, 2, 5, 1, 4, 3, 2,  0, 0, 0, 0, 0, 0);
    step("ros_first", 1, 1, 2, 5, 0, 0, 0, 0,  2, 5, 0, 0, 0, 0);
    step("idle", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Channel burst with ROS idle; channel inputs change after grant and must be ignored
    step("ch_b1", 1, 0, 0, 0, 1, 4, 3, 2,  4, 3, 1, 1, 0, 0);
    step("ch_b2", 1, 0, 0, 0, 0, 7, 1, 0,  4, 3, 0, 1, 1, 0);
    step("ch_b3", 1, 0, 0, 0, 0, 2, 2, 3,  4, 3, 0, 1, 1, 0);
    step("ch_end", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Starvation: ROS wins 8 times, then the channel is forced in
    for (int i = 0; i < 8; i++) begin
      step("starve_ros", 1, 1, 1, 2, 1, 5, 6, 1,  1, 2, 0, 0, 0, 0);
    end
    step("starve_gnt", 1, 1, 1, 2, 1, 5, 6, 1,  5, 6, 1, 1, 1, 0);
    step("starve_b2", 1, 1, 1, 2, 0, 0, 0, 0,  5, 6, 0, 1, 1, 0);
    step("starve_fair", 1, 1, 1, 2, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0);

    // Back-to-back single beats with the request held high
    for (int i = 0; i < 8; i++) begin
      step("b2b_ros", 1, 1, 2, 2, 1, 3, 1, 0,  2, 2, 0, 0, 0, 0);
    end
    step("b2b_gnt1", 1, 1, 2, 2, 1, 3, 1, 0,  3, 1, 1, 1, 1, 0);
    step("b2b_fair", 1, 1, 2, 2, 1, 3, 1, 0,  2, 2, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step("b2b_reacc", 1, 1, 2, 2, 1, 3, 1, 0,  2, 2, 0, 0, 0, 0);
    end
    step("b2b_gnt2", 1, 1, 2, 2, 1, 3, 1, 0,  3, 1, 1, 1, 1, 0);
    step("b2b_after", 1, 1, 2, 2, 0, 0, 0, 0,  2, 2, 0, 0, 0, 0);
    step("b2b_idle", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Illegal channel RY code 6
`ifdef X2050_RYARB_CODECHK_EN
    step("ill_gnt", 1, 0, 0, 0, 1, 6, 4, 1,  0, 0, 1, 0, 0, 1);
    step("ill_next", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
`else
    step("ill_b1", 1, 0, 0, 0, 1, 6, 4, 1,  0, 4, 1, 1, 0, 0);
    step("ill_b2", 1, 0, 0, 0, 0, 0, 0, 0,  0, 4, 0, 1, 1, 0);
`endif
    step("ill_end", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    // Reset in the middle of a 4-beat burst
    step("mid_b1", 1, 0, 0, 0, 1, 3, 7, 3,  3, 7, 1, 1, 0, 0);
    step("mid_b2", 1, 0, 0, 0, 0, 0, 0, 0,  3, 7, 0, 1, 1, 0);
    step("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("mid_idle", 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    step("mid_regnt", 1, 0, 0, 0, 1, 1, 1, 0,  1, 1, 1, 1, 0, 0);
    step("mid_ros", 1, 1, 4, 4, 0, 0, 0, 0,  4, 4, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x2050ryarb.md
Name: x2050ryarb

Overview:
- Arbitrates the right adder input selection (RY source code and LX code) between two requesters: the ROS microword path and a channel cycle-steal requester.
- Channel transfers run as multi-beat bursts of 1-4 cycles. The microword path has priority, but a starvation counter guarantees the channel forward progress.
- Outputs are registered RY/LX codes that feed the right adder input mux directly. Stall and beat strobes coordinate the two sides.

Parameters:
- STARVE_LIMIT, 8, number of consecutive lost arbitration cycles after which the channel overrides ROS.
- CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous reset, active-low (0 = reset).
- i_ros_valid  input  1  microword requests the adder right input this cycle.
- i_ros_ry  input  3  microword RY source code.
- i_ros_lx  input  3  microword LX code.
- i_ch_req  input  1  channel request, level; held until o_ch_gnt.
- i_ch_ry  input  3  channel RY code; sampled at grant.
- i_ch_lx  input  3  channel LX code; sampled at grant.
- i_ch_len  input  2  burst length minus 1 (0 = 1 beat, 3 = 4 beats); sampled at grant.
- o_ry  output  3  registered RY code to the adder input mux.
- o_lx  output  3  registered LX code.
- o_ch_gnt  output  1  one-cycle pulse on the first channel beat.
- o_ch_beat  output  1  high on every cycle o_ry/o_lx carry channel codes.
- o_ros_stall  output  1  high on every cycle the ROS request is not being served.
- o_ch_err  output  1  illegal RY code at grant; present only with the optional feature.

Behaviour:
- Reset: when i_reset = 0 at a rising edge, all of the following are forced to 0 on the next cycle: o_ry, o_lx, o_ch_gnt, o_ch_beat, o_ros_stall, o_ch_err, the state (IDLE), the beat counter, the starvation counter and the fairness flag.
- Reset mid-burst aborts the burst with no further beats. The requester must re-request.

States:
- IDLE: ROS owns the input.
- XFER: the channel burst is in progress.

Latency:
- All outputs are registered. A decision made in cycle N appears on the outputs in cycle N+1.

IDLE decision each cycle, in priority order:
1. Channel wins if all hold: i_ch_req=1, fairness flag=0, and either i_ros_valid=0 or starve_cnt==STARVE_LIMIT.
   - Latch i_ch_ry, i_ch_lx, i_ch_len.
   - Next cycle: o_ry/o_lx = latched codes, o_ch_gnt=1, o_ch_beat=1.
   - o_ros_stall = i_ros_valid (the value sampled at decision time); enter XFER with beats_left = len.
2. Otherwise, if i_ros_valid=1: next o_ry/o_lx = i_ros_ry/i_ros_lx, o_ros_stall=0.
3. Otherwise: next o_ry=0, o_lx=0 (zero source, no LX modification).

Starvation counter:
- Increments in IDLE on cycles where i_ch_req=1 and ROS wins.
- Saturates at STARVE_LIMIT and clears on grant.
- With STARVE_LIMIT=0, the channel always wins.

XFER:
- Each cycle emits the latched codes with o_ch_beat=1 and o_ros_stall=1.
- o_ch_gnt is high only on the first beat.
- beats_left decrements. Exit to IDLE after the beat where beats_left==0, so total beats = len+1.

Fairness:
- Exiting XFER sets the fairness flag for one IDLE decision cycle. During that cycle the channel cannot win, so ROS gets at least one served cycle between bursts even if i_ch_req stays high.
- If i_ros_valid=0 in that cycle, the flag still clears and the outputs go to 0/0. There is one idle cycle; this is accepted.

Requester rules:
- The requester drops i_ch_req in the o_ch_gnt cycle or later. A request still high after the burst is treated as a new request.
- i_ch_* inputs are ignored outside the grant decision cycle.

Simultaneous reset and request: reset wins.

Optional Feature:
- Macro X2050_RYARB_CODECHK_EN. Legal RY codes are 0-5.
- With the macro: a grant with i_ch_ry of 6 or 7 is refused.
  - No XFER is entered. o_ch_gnt pulses, o_ch_beat=0 and o_ch_err=1 for one cycle; the ROS path is served normally that cycle.
  - The starvation counter clears.
- Without the macro: the o_ch_err port is absent, and channel RY codes 6/7 are emitted as 0 for the whole burst.

Test Plan:
- Reset: hold i_reset=0 for 2 cycles with requests active -> all outputs 0. Release -> the first ROS request i_ros_ry=2, i_ros_lx=5 appears on o_ry=2, o_lx=5 one cycle later.
- Idle channel: i_ros_valid=0, i_ch_req=1, ry=4, len=2 -> 3 beats of o_ry=4 with o_ch_beat=1. o_ch_gnt is high on beat 1 only; then IDLE.
- Starvation: i_ros_valid=1 continuously, i_ch_req=1, STARVE_LIMIT=8 -> ROS is served for 8 cycles, then the channel is granted. o_ros_stall=1 for exactly len+1 cycles, then ROS resumes for at least 1 cycle.
- Back-to-back: i_ch_req held high with len=0 and ROS valid -> beat, then a ROS cycle, then the channel again only after the starvation limit re-accumulates.
- Mid-burst reset: len=3, assert i_reset=0 at beat 2 -> next cycle all outputs 0 and the state is IDLE. No further beats.
- Optional feature: with X2050_RYARB_CODECHK_EN, i_ch_ry=6 and ROS idle -> o_ch_gnt=1, o_ch_err=1, o_ch_beat=0, o_ry=0. Without it -> 1..4 beats with o_ry=0.
